// File: rtl/blur_pkg.sv
// Shared definitions for the box-blur stream.
//   - freq_flag kernel-select codes
//   - fixed-point reciprocals of K*K (Q16), used to turn a window sum into a mean
//   - code_to_k(): decodes freq_flag into the kernel edge length, clamped to max_k
//   - recip_of():  returns the reciprocal matching a kernel edge length
package blur_pkg;

  localparam logic [2:0] FREQ_1X1 = 3'b000;
  localparam logic [2:0] FREQ_3X3 = 3'b001;
  localparam logic [2:0] FREQ_5X5 = 3'b010;
  localparam logic [2:0] FREQ_7X7 = 3'b011;

  localparam int unsigned RECIP_1 = 65536;
  localparam int unsigned RECIP_3 = 7282;
  localparam int unsigned RECIP_5 = 2621;
  localparam int unsigned RECIP_7 = 1337;
  localparam int RECIP_W = 17;

  function automatic logic [2:0] code_to_k(input logic [2:0] code, input int unsigned max_k);
    logic [2:0] k;
    case (code)
      FREQ_3X3: k = 3'd3;
      FREQ_5X5: k = 3'd5;
      FREQ_7X7: k = 3'd7;
      default:  k = 3'd1;
    endcase
    if (32'(k) > max_k) k = 3'(max_k);
    return k;
  endfunction

  function automatic logic [RECIP_W-1:0] recip_of(input logic [2:0] k);
    case (k)
      3'd3:    return RECIP_W'(RECIP_3);
      3'd5:    return RECIP_W'(RECIP_5);
      3'd7:    return RECIP_W'(RECIP_7);
      default: return RECIP_W'(RECIP_1);
    endcase
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage, addressed by column.
//   clk   : clock
//   en    : accepted-pixel strobe; writes wdata at addr
//   addr  : column being processed
//   wdata : pixel to store for the next line
//   rdata : pixel stored at addr during the previous line (combinational read)
// Chaining instances (rdata -> wdata) yields successively older rows per column.
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 12,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; stale contents are never used because
  // the top clamps vertical taps to row 0 until enough rows of a frame exist.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/box_blur_stream.sv
// Streaming causal box blur, K x K per channel with K in {1,3,5,7} (<= MAX_K).
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   ready_in    : input pixel strobe; data_in/sof_in/freq_flag sampled when high
//   sof_in      : accepted pixel is (0,0) of a new frame
//   freq_flag   : kernel select, latched at each (0,0)
//   data_in     : input pixel, channel 0 in the LSBs
//   ready_out   : output valid, exactly 3 cycles after ready_in
//   data_out    : blurred pixel, 0 while ready_out is low
//   frame_done  : pulse with the output of the last pixel of a frame
// Pipeline: accept (window shift) -> window sum -> scale/saturate -> output.
module box_blur_stream
  import blur_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int NUM_CH     = 3,
  parameter int CH_W       = 4,
  parameter int MAX_K      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready_in,
  input  logic                     sof_in,
  input  logic [2:0]               freq_flag,
  input  logic [NUM_CH*CH_W-1:0]   data_in,
  output logic                     ready_out,
  output logic [NUM_CH*CH_W-1:0]   data_out,
  output logic                     frame_done
);

  localparam int PIX_W  = NUM_CH * CH_W;
  localparam int SUM_W  = CH_W + 6;
  localparam int PROD_W = SUM_W + RECIP_W + 1;
  localparam int Q_W    = PROD_W - 16;
  localparam int CH_MAX = 2**CH_W - 1;
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  // ---------------- position tracking and kernel latch ----------------
  logic [COL_W-1:0] col, eff_col;
  logic [ROW_W-1:0] row, eff_row;
  logic [2:0]       k_frame, k_pix;
  logic             at_origin, last_pix;

  // sof_in overrides the counters for the pixel that carries it.
  assign eff_col   = sof_in ? '0 : col;
  assign eff_row   = sof_in ? '0 : row;
  assign at_origin = (eff_col == '0) && (eff_row == '0);
  assign k_pix     = at_origin ? code_to_k(freq_flag, MAX_K) : k_frame;
  assign last_pix  = (eff_col == COL_W'(IMG_WIDTH - 1)) && (eff_row == ROW_W'(IMG_HEIGHT - 1));

  // NOTE: all clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      k_frame <= 3'd1;
    end else if (ready_in) begin
      k_frame <= k_pix;
      if (eff_col == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (eff_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
    end
  end

  // ---------------- vertical taps from chained line buffers ----------------
  logic [PIX_W-1:0] lb_out [MAX_K-1];
  logic [PIX_W-1:0] raw    [MAX_K];
  logic [PIX_W-1:0] vtap   [MAX_K];

  for (genvar i = 0; i < MAX_K - 1; i++) begin : g_lb
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb (
      .clk   (clk),
      .en    (ready_in),
      .addr  (eff_col),
      .wdata ((i == 0) ? data_in : lb_out[(i == 0) ? 0 : i - 1]),
      .rdata (lb_out[i])
    );
  end

  // Tap j is row r-j; rows above the frame top clamp to row 0, which is tap r.
  // NOTE: every always_comb output gets a value on every path so no latch forms.
  always_comb begin
    raw[0] = data_in;
    for (int i = 1; i < MAX_K; i++) raw[i] = lb_out[i-1];
    for (int j = 0; j < MAX_K; j++) begin
      int sel;
      sel     = (int'(eff_row) < j) ? int'(eff_row) : j;
      vtap[j] = raw[sel];
    end
  end

  // ---------------- horizontal windows (stage 0) ----------------
  // hwin[j][d] holds row tap j at column c-d. Loading the whole row at column 0
  // clamps columns left of the frame edge to column 0.
  logic [PIX_W-1:0] hwin [MAX_K][MAX_K];

  always_ff @(posedge clk) begin
    if (ready_in) begin
      for (int j = 0; j < MAX_K; j++) begin
        hwin[j][0] <= vtap[j];
        for (int d = 1; d < MAX_K; d++)
          hwin[j][d] <= (eff_col == '0) ? vtap[j] : hwin[j][d-1];
      end
    end
  end

  logic       v0, v1, last0, last1;
  logic [2:0] k0, k1;

  // ---------------- window sum (stage 1) ----------------
  logic [SUM_W-1:0] sum_c [NUM_CH];
  logic [SUM_W-1:0] sum_q [NUM_CH];

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum_c[ch] = '0;
      for (int j = 0; j < MAX_K; j++)
        for (int d = 0; d < MAX_K; d++)
          if (j < int'(k0) && d < int'(k0))
            sum_c[ch] = sum_c[ch] + SUM_W'(hwin[j][d][ch*CH_W +: CH_W]);
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) sum_q[ch] <= sum_c[ch];
  end

  // ---------------- scale, round, saturate (stage 2) ----------------
  logic [RECIP_W-1:0] recip;
  logic [PIX_W-1:0]   mean_pix;

  always_comb begin
    recip    = recip_of(k1);
    mean_pix = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic [PROD_W-1:0] prod;
      logic [Q_W-1:0]    q;
      prod = PROD_W'(sum_q[ch]) * PROD_W'(recip) + PROD_W'(32768);
      q    = prod[PROD_W-1:16];
      mean_pix[ch*CH_W +: CH_W] = (q > Q_W'(CH_MAX)) ? {CH_W{1'b1}} : q[CH_W-1:0];
    end
  end

  // ---------------- pipeline control and outputs ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0         <= 1'b0;
      v1         <= 1'b0;
      last0      <= 1'b0;
      last1      <= 1'b0;
      k0         <= 3'd1;
      k1         <= 3'd1;
      ready_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      v0         <= ready_in;
      last0      <= ready_in && last_pix;
      k0         <= ready_in ? k_pix : k0;
      v1         <= v0;
      last1      <= last0;
      k1         <= k0;
      ready_out  <= v1;
      data_out   <= v1 ? mean_pix : '0;
      frame_done <= v1 && last1;
    end
  end

endmodule
